sqrt_seq: RTL and testbench
===========================

Name: sqrt_seq

Overview:
- Initiator/sequencer for the iterative square-root engine: the other end of its start/argument/result/done handshake.
- Accepts a stream of single-precision magnitudes-squared, one per FFT bin, from the spectrum path. For each value it issues one square-root operation, waits for completion, and emits the result tagged with bin index and frame-last.
- Sits between the power-spectrum buffer and the output formatter.

Parameters:
- N_POINTS, 16, bins per frame; the index wraps at N_POINTS-1.
- IDX_W, 4, index width; must satisfy 2^IDX_W >= N_POINTS.
- TIMEOUT_CYCLES, 1024, watchdog limit per operation (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- n_reset  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_data  in  32  IEEE-754 single argument.
- in_ready  out  1  block can accept a word.
- sq_start  out  1  one-cycle start pulse to the sqrt engine.
- sq_argument  out  32  argument to the engine; held stable for the whole operation.
- sq_result  in  32  engine result.
- sq_done  in  1  engine done/idle level: high when idle, low while calculating.
- out_valid  out  1  result valid.
- out_data  out  32  sqrt result.
- out_idx  out  IDX_W  bin index of the result.
- out_last  out  1  high when out_idx == N_POINTS-1.
- out_err  out  1  result is a substituted value, not a computed one.
- out_ready  in  1  downstream accepts the result.

Behaviour:
- Reset values (asynchronous, on n_reset low):
  - All outputs 0, except sq_argument = 32'h3F000000.
  - State IDLE, index counter 0.
  - Reset mid-operation abandons the operation; no output is produced for it.
- in_ready = (state==IDLE) && !out_valid. An input transfer occurs when in_valid && in_ready; the word is latched into sq_argument.
- States and transitions:
  - IDLE: on transfer, if in_data[30:0]==0 or in_data[31]==1, go to OUTPUT with out_data=32'h0 and out_err = in_data[31]. The engine is not started for these (zero would divide by zero). Otherwise go to ISSUE.
  - ISSUE: sq_start=1 for exactly this cycle; go to WAIT_BUSY.
  - WAIT_BUSY: wait for sq_done==0 (the engine drops done the cycle after it leaves idle); then go to WAIT_DONE. Completion is never taken from sq_done before busy has been seen.
  - WAIT_DONE: on sq_done==1, capture out_data=sq_result and out_err=0; go to OUTPUT.
  - OUTPUT: out_valid=1 with out_idx = index counter and out_last as above. Hold all out_* stable until out_ready. On out_valid && out_ready: clear out_valid, increment the index (wrap N_POINTS-1 -> 0), return to IDLE.
- out_ready high on the first OUTPUT cycle: the transfer completes that cycle, and the next input can be accepted one cycle later.
- Latency: input accept to out_valid = engine latency + 3 cycles. Bypass path: 1 cycle.
- sq_start is never asserted outside ISSUE. sq_argument changes only on an input transfer.

Optional Feature:
- Macro: SQRT_SEQ_TIMEOUT_EN.
- With the macro defined:
  - A cycle counter runs in WAIT_BUSY and WAIT_DONE.
  - If it reaches TIMEOUT_CYCLES, the block goes to OUTPUT with out_data=32'h7FC00000 (quiet NaN) and out_err=1.
  - A sticky output port timeout_flag (1 bit, reset 0) is set and is cleared only by reset.
- Without the macro: no counter, no timeout_flag port; the block waits indefinitely.

Decomposition:
- Shared package fft_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, OUTPUT);
  - constants FP_ZERO=32'h0, FP_QNAN=32'h7FC00000, FP_HALF=32'h3F000000.
- One natural sub-module, bin_counter: wrapping index counter with a last flag, parameterised by N_POINTS.
- The FSM and output register stay in sqrt_seq.

Test Plan:
- Argument 4.0 (32'h40800000) with a behavioural engine model of 20-cycle latency -> exactly one sq_start pulse; out_data=32'h40000000, out_idx=0, out_err=0, out_valid 23 cycles after accept.
- Argument 32'h00000000, then 32'hC0800000 -> no sq_start for either; outputs 32'h0 with out_err=0, then 32'h0 with out_err=1, each 1 cycle after accept.
- 16 consecutive arguments 1.0 with out_ready held high -> out_idx 0..15, out_last only on idx 15, next frame restarts at idx 0.
- out_ready held low 10 cycles while out_valid -> out_data/out_idx stable, in_ready=0, no sq_start; accepted on release.
- Engine that holds sq_done high 5 cycles after start -> block stays in WAIT_BUSY with no early completion; correct result when done falls then rises.
- n_reset asserted during WAIT_DONE -> all outputs reset immediately. With SQRT_SEQ_TIMEOUT_EN and a stuck engine -> QNAN output with out_err=1 after 1024 cycles, and timeout_flag=1.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and constants for the spectrum square-root sequencer.
package fft_pkg;

  localparam int unsigned FP_W = 32;

  localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;
  localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;
  localparam logic [FP_W-1:0] FP_HALF = 32'h3F00_0000;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    OUTPUT    = 3'd4
  } sq_state_e;

  // Result payload presented to the output formatter.
  typedef struct packed {
    logic            err;
    logic [FP_W-1:0] data;
  } sq_res_t;

  // Zero and negative arguments never reach the engine (zero would divide by zero).
  function automatic logic is_bypass(input logic [FP_W-1:0] x);
    return x[FP_W-1] | (x[FP_W-2:0] == (FP_W-1)'(0));
  endfunction

endpackage

// File: rtl/bin_counter.sv
// Wrapping FFT bin index counter with a registered last-bin flag.
module bin_counter #(
  parameter int unsigned N_POINTS = 16,
  parameter int unsigned IDX_W    = 4
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             inc_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             last_o
);

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_POINTS - 1);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic             last_q, last_d;

  // Next index: advance on inc, wrapping after the last bin.
  always_comb begin
    idx_d = idx_q;
    if (inc_i) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
    end
    last_d = (idx_d == IDX_MAX);
  end

  // Index and last-flag registers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      idx_q  <= '0;
      last_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      last_q <= last_d;
    end
  end

  assign idx_o  = idx_q;
  assign last_o = last_q;

endmodule

// File: rtl/sqrt_seq.sv
// Sequencer driving the iterative sqrt engine, one operation per spectrum bin.
// Optional watchdog enabled by defining SQRT_SEQ_TIMEOUT_EN.
module sqrt_seq
  import fft_pkg::*;
#(
  parameter int unsigned N_POINTS = 16,
  parameter int unsigned IDX_W    = 4
`ifdef SQRT_SEQ_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             in_valid,
  input  logic [FP_W-1:0]  in_data,
  output logic             in_ready,
  output logic             sq_start,
  output logic [FP_W-1:0]  sq_argument,
  input  logic [FP_W-1:0]  sq_result,
  input  logic             sq_done,
  output logic             out_valid,
  output logic [FP_W-1:0]  out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_err,
`ifdef SQRT_SEQ_TIMEOUT_EN
  output logic             timeout_flag,
`endif
  input  logic             out_ready
);

  sq_state_e       state_q, state_d;
  logic [FP_W-1:0] arg_q, arg_d;
  logic            start_q, start_d;
  logic            valid_q, valid_d;
  logic            ready_q, ready_d;
  sq_res_t         res_q, res_d;
  logic            idx_inc;

`ifdef SQRT_SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             flag_q, flag_d;
`endif

  // Next-state, handshake and result-capture logic.
  always_comb begin
    state_d = state_q;
    arg_d   = arg_q;
    start_d = 1'b0;
    valid_d = valid_q;
    res_d   = res_q;
    idx_inc = 1'b0;
`ifdef SQRT_SEQ_TIMEOUT_EN
    tmo_d   = tmo_q;
    flag_d  = flag_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (in_valid && ready_q) begin
          arg_d = in_data;
          if (is_bypass(in_data)) begin
            res_d.data = FP_ZERO;
            res_d.err  = in_data[FP_W-1];
            valid_d    = 1'b1;
            state_d    = OUTPUT;
          end else begin
            start_d = 1'b1;
            state_d = ISSUE;
`ifdef SQRT_SEQ_TIMEOUT_EN
            tmo_d   = '0;
`endif
          end
        end
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // Done is only meaningful once the engine has been seen busy.
        if (!sq_done) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (sq_done) begin
          res_d.data = sq_result;
          res_d.err  = 1'b0;
          valid_d    = 1'b1;
          state_d    = OUTPUT;
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          valid_d = 1'b0;
          idx_inc = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef SQRT_SEQ_TIMEOUT_EN
    // Watchdog: a real completion in WAIT_DONE takes priority over expiry.
    if ((state_q == WAIT_BUSY) || ((state_q == WAIT_DONE) && !sq_done)) begin
      if (tmo_q == TMO_LAST) begin
        res_d.data = FP_QNAN;
        res_d.err  = 1'b1;
        valid_d    = 1'b1;
        flag_d     = 1'b1;
        state_d    = OUTPUT;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
`endif

    ready_d = (state_d == IDLE) && !valid_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      arg_q   <= FP_HALF;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      arg_q   <= arg_d;
      start_q <= start_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      res_q   <= res_d;
    end
  end

`ifdef SQRT_SEQ_TIMEOUT_EN
  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      tmo_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      tmo_q  <= tmo_d;
      flag_q <= flag_d;
    end
  end

  assign timeout_flag = flag_q;
`endif

  bin_counter #(
    .N_POINTS (N_POINTS),
    .IDX_W    (IDX_W)
  ) u_bin_counter (
    .clk     (clk),
    .n_reset (n_reset),
    .inc_i   (idx_inc),
    .idx_o   (out_idx),
    .last_o  (out_last)
  );

  assign in_ready    = ready_q;
  assign sq_start    = start_q;
  assign sq_argument = arg_q;
  assign out_valid   = valid_q;
  assign out_data    = res_q.data;
  assign out_err     = res_q.err;

endmodule

// File: tb/tb_sqrt_seq.sv
// Directed self-checking bench for sqrt_seq with a behavioural sqrt engine.
module tb_sqrt_seq;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        sq_start;
  logic [31:0] sq_argument;
  logic [31:0] sq_result;
  logic        sq_done;
  logic        out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_idx;
  logic        out_last;
  logic        out_err;
  logic        out_ready;
`ifdef SQRT_SEQ_TIMEOUT_EN
  logic        timeout_flag;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc     = 0;
  int start_cnt = 0;

  // Engine model controls.
  int eng_lat   = 20;
  int eng_hold  = 0;
  bit eng_stuck = 1'b0;
  int eng_phase;
  int eng_cnt;
  logic        eng_done;
  logic [31:0] eng_res;

  sqrt_seq dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .sq_start    (sq_start),
    .sq_argument (sq_argument),
    .sq_result   (sq_result),
    .sq_done     (sq_done),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_idx     (out_idx),
    .out_last    (out_last),
    .out_err     (out_err),
`ifdef SQRT_SEQ_TIMEOUT_EN
    .timeout_flag(timeout_flag),
`endif
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sq_start) start_cnt <= start_cnt + 1;
  end

  // Hand-computed square roots for the arguments used here.
  function automatic logic [31:0] sqrt_ref(input logic [31:0] a);
    case (a)
      32'h4080_0000: return 32'h4000_0000; // 4  -> 2
      32'h3F80_0000: return 32'h3F80_0000; // 1  -> 1
      32'h4110_0000: return 32'h4040_0000; // 9  -> 3
      32'h4180_0000: return 32'h4080_0000; // 16 -> 4
      default:       return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Behavioural engine: optional done-high hold, then eng_lat busy cycles.
  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      eng_done  <= 1'b1;
      eng_res   <= 32'h0;
      eng_phase <= 0;
      eng_cnt   <= 0;
    end else begin
      case (eng_phase)
        0: if (sq_start) begin
          if (eng_hold > 0) begin
            eng_phase <= 1;
            eng_cnt   <= eng_hold - 1;
          end else begin
            eng_done  <= 1'b0;
            eng_phase <= 2;
            eng_cnt   <= eng_lat - 1;
          end
        end
        1: if (eng_cnt == 0) begin
          eng_done  <= 1'b0;
          eng_phase <= 2;
          eng_cnt   <= eng_lat - 1;
        end else begin
          eng_cnt <= eng_cnt - 1;
        end
        default: if (eng_cnt != 0) begin
          eng_cnt <= eng_cnt - 1;
        end else if (!eng_stuck) begin
          eng_done  <= 1'b1;
          eng_res   <= sqrt_ref(sq_argument);
          eng_phase <= 0;
        end
      endcase
    end
  end

  assign sq_done   = eng_done;
  assign sq_result = eng_res;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one word; acc records the cycle count before the accepting edge.
  task automatic send(input logic [31:0] d);
    int t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("send_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    acc      = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    int t = 0;
    while (!out_valid && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("out_valid_seen", 32'(out_valid), 32'd1);
    lat = cyc - acc;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("pop_valid_clr", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int s0;

    n_reset = 1'b0; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sq_start",  32'(sq_start),  32'd0);
    check("rst_argument",  sq_argument,    32'h3F00_0000);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_data",  out_data,       32'h0);
    check("rst_out_idx",   32'(out_idx),   32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_out_err",   32'(out_err),   32'd0);
`ifdef SQRT_SEQ_TIMEOUT_EN
    check("rst_tmo_flag",  32'(timeout_flag), 32'd0);
`endif
    n_reset = 1'b1;
    @(negedge clk);
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // sqrt(4.0) through the engine, 20-cycle latency.
    s0 = start_cnt;
    send(32'h4080_0000);
    check("four_arg", sq_argument, 32'h4080_0000);
    wait_out(lat);
    check("four_lat",    32'(lat), 32'd23);
    check("four_data",   out_data, 32'h4000_0000);
    check("four_idx",    32'(out_idx), 32'd0);
    check("four_err",    32'(out_err), 32'd0);
    check("four_last",   32'(out_last), 32'd0);
    check("four_starts", 32'(start_cnt - s0), 32'd1);
    pop();
    check("four_in_ready_after", 32'(in_ready), 32'd1);

    // Bypass: zero then negative.
    s0 = start_cnt;
    send(32'h0000_0000);
    wait_out(lat);
    check("zero_lat",  32'(lat), 32'd1);
    check("zero_data", out_data, 32'h0);
    check("zero_err",  32'(out_err), 32'd0);
    check("zero_idx",  32'(out_idx), 32'd1);
    pop();
    send(32'hC080_0000);
    wait_out(lat);
    check("neg_lat",    32'(lat), 32'd1);
    check("neg_data",   out_data, 32'h0);
    check("neg_err",    32'(out_err), 32'd1);
    check("neg_idx",    32'(out_idx), 32'd2);
    check("neg_starts", 32'(start_cnt - s0), 32'd0);
    pop();

    // Backpressure on sqrt(9.0).
    send(32'h4110_0000);
    wait_out(lat);
    s0 = start_cnt;
    for (int i = 0; i < 10; i++) begin
      check("bp_data",     out_data, 32'h4040_0000);
      check("bp_idx",      32'(out_idx), 32'd3);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_valid",    32'(out_valid), 32'd1);
      @(negedge clk);
    end
    check("bp_starts", 32'(start_cnt - s0), 32'd0);
    pop();
    check("bp_in_ready_rel", 32'(in_ready), 32'd1);

    // Engine keeps done high 5 cycles after start.
    eng_hold = 5;
    send(32'h4180_0000);
    repeat (4) @(negedge clk);
    check("hold_no_early", 32'(out_valid), 32'd0);
    wait_out(lat);
    check("hold_lat",  32'(lat), 32'd28);
    check("hold_data", out_data, 32'h4080_0000);
    check("hold_idx",  32'(out_idx), 32'd4);
    check("hold_err",  32'(out_err), 32'd0);
    pop();
    eng_hold = 0;

    // Reset during WAIT_DONE abandons the operation.
    send(32'h4080_0000);
    repeat (8) @(negedge clk);
    s0 = start_cnt;
    n_reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_start", 32'(sq_start), 32'd0);
    check("mid_rst_arg",   sq_argument, 32'h3F00_0000);
    check("mid_rst_idx",   32'(out_idx), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    n_reset = 1'b1;
    repeat (30) @(negedge clk);
    check("mid_rst_no_out",    32'(out_valid), 32'd0);
    check("mid_rst_no_starts", 32'(start_cnt - s0), 32'd0);

    // Full frame of 1.0 with out_ready held high, then wrap.
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      send(32'h3F80_0000);
      wait_out(lat);
      check("frame_data", out_data, 32'h3F80_0000);
      check("frame_idx",  32'(out_idx), (i == 16) ? 32'd0 : 32'(i));
      check("frame_last", 32'(out_last), (i == 15) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("frame_idle", 32'(out_valid), 32'd0);

`ifdef SQRT_SEQ_TIMEOUT_EN
    // Stuck engine triggers the watchdog.
    eng_stuck = 1'b1;
    send(32'h4080_0000);
    wait_out(lat);
    check("tmo_data", out_data, 32'h7FC0_0000);
    check("tmo_err",  32'(out_err), 32'd1);
    check("tmo_flag", 32'(timeout_flag), 32'd1);
    check("tmo_lat_min", 32'(lat >= 1024), 32'd1);
    pop();
    check("tmo_flag_sticky", 32'(timeout_flag), 32'd1);
    n_reset = 1'b0;
    #1;
    check("tmo_flag_rst", 32'(timeout_flag), 32'd0);
    @(negedge clk);
    n_reset = 1'b1;
    eng_stuck = 1'b0;
    @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
